// File: rtl/game_ctrl_if.sv
// ============================================================================
// Module : game_ctrl_if
// Brief  : Move / load / new-game request bundle for the tile-merge controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface game_ctrl_if;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        new_game;
    logic        load_en;
    logic [63:0] load_data;

    modport master (
        output move_valid, move_dir, new_game, load_en, load_data,
        input  move_ready
    );

    modport slave (
        input  move_valid, move_dir, new_game, load_en, load_data,
        output move_ready
    );
endinterface

`default_nettype wire

// File: rtl/game_ctrl.sv
// ============================================================================
// Module : game_ctrl
// Brief  : 4x4 tile-merge sequencer: slide/merge, LFSR spawn, win/lose check,
//          vblank-aligned commit to the display grid.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module game_ctrl #(
    parameter int          WIN_VALUE = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  wire logic       vgaclk,
    input  wire logic       rst,
    input  wire logic [9:0] vc,
    game_ctrl_if.slave      bus,
    output logic [3:0]      grid [0:15],
    output logic [1:0]      state
);

    localparam logic [3:0]  c_win      = 4'(WIN_VALUE);
    localparam logic [15:0] c_lfsr_tap = 16'hB400;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_SLIDE   = 3'd2,
        S_SPAWN   = 3'd3,
        S_CHECK   = 3'd4,
        S_WAIT_VB = 3'd5
    } fsm_t;

    fsm_t        r_fsm;
    logic [3:0]  r_work [0:15];
    logic [15:0] r_lfsr;
    logic [1:0]  r_dir;
    logic [1:0]  r_line;
    logic        r_changed;
    logic [3:0]  r_probe;
    logic        r_spawn2;
    logic [1:0]  r_result;
    logic        r_ready;

    logic [15:0] w_lfsr_next;
    logic [3:0]  w_idx [0:3];
    logic [15:0] w_in;
    logic [15:0] w_out;
    logic        w_diff;
    logic        w_won;
    logic        w_empty;
    logic        w_pair;

    // Position j of line k, counted from the edge tiles move toward.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] k,
                                            input logic [1:0] j);
        case (dir)
            2'd0:    return {k, j};
            2'd1:    return {k, ~j};
            2'd2:    return {j, k};
            default: return {~j, k};
        endcase
    endfunction

    function automatic logic [15:0] slide_line(input logic [15:0] l);
        logic [3:0]  c [0:4];
        logic [15:0] o;
        logic [2:0]  n;
        logic [2:0]  m;
        logic        skip;
        for (int j = 0; j < 5; j++) c[j] = 4'd0;
        n = 3'd0;
        for (int j = 0; j < 4; j++) begin
            if (l[4*j +: 4] != 4'd0) begin
                c[n] = l[4*j +: 4];
                n    = n + 3'd1;
            end
        end
        o    = 16'd0;
        m    = 3'd0;
        skip = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[j] != 4'd0) begin
                if (c[j] == c[j+1] && c[j] != 4'hF) begin
                    o[4*m +: 4] = c[j] + 4'd1;
                    skip        = 1'b1;
                end else begin
                    o[4*m +: 4] = c[j];
                end
                m = m + 3'd1;
            end
        end
        return o;
    endfunction

    assign w_lfsr_next    = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_lfsr_tap) : (r_lfsr >> 1);
    assign bus.move_ready = r_ready;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_idx[j]       = cell_idx(r_dir, r_line, 2'(j));
            w_in[4*j +: 4] = r_work[w_idx[j]];
        end
        w_out  = slide_line(w_in);
        w_diff = (w_out != w_in);
    end

    always_comb begin
        w_won   = 1'b0;
        w_empty = 1'b0;
        w_pair  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (r_work[i] >= c_win) w_won = 1'b1;
            if (r_work[i] == 4'd0)  w_empty = 1'b1;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (r_work[r*4+c] == r_work[r*4+c+1]) w_pair = 1'b1;
        for (int i = 0; i < 12; i++)
            if (r_work[i] == r_work[i+4]) w_pair = 1'b1;
    end

    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            r_fsm     <= S_INIT;
            r_lfsr    <= LFSR_SEED;
            r_dir     <= 2'd0;
            r_line    <= 2'd0;
            r_changed <= 1'b0;
            r_probe   <= 4'd0;
            r_spawn2  <= 1'b0;
            r_result  <= 2'd0;
            r_ready   <= 1'b0;
            state     <= 2'd0;
            for (int i = 0; i < 16; i++) begin
                r_work[i] <= 4'd0;
                grid[i]   <= 4'd0;
            end
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_fsm)
                S_INIT: begin
                    r_spawn2 <= 1'b1;
                    r_probe  <= r_lfsr[3:0];
                    r_fsm    <= S_SPAWN;
                end
                S_IDLE: begin
                    if (bus.new_game) begin
                        for (int i = 0; i < 16; i++) r_work[i] <= 4'd0;
                        r_ready <= 1'b0;
                        r_fsm   <= S_INIT;
                    end else if (bus.load_en) begin
                        for (int i = 0; i < 16; i++) begin
                            r_work[i] <= bus.load_data[4*i +: 4];
                            grid[i]   <= bus.load_data[4*i +: 4];
                        end
                        state <= 2'd0;
                    end else if (bus.move_valid && state == 2'd0) begin
                        r_dir     <= bus.move_dir;
                        r_line    <= 2'd0;
                        r_changed <= 1'b0;
                        r_ready   <= 1'b0;
                        r_fsm     <= S_SLIDE;
                    end
                end
                S_SLIDE: begin
                    for (int j = 0; j < 4; j++) r_work[w_idx[j]] <= w_out[4*j +: 4];
                    r_line    <= r_line + 2'd1;
                    r_changed <= r_changed | w_diff;
                    if (r_line == 2'd3) begin
                        if (r_changed || w_diff) begin
                            r_spawn2 <= 1'b0;
                            r_probe  <= r_lfsr[3:0];
                            r_fsm    <= S_SPAWN;
                        end else begin
                            r_ready <= 1'b1;
                            r_fsm   <= S_IDLE;
                        end
                    end
                end
                S_SPAWN: begin
                    // Linear probe from the entry position; a second pass re-seeds the probe.
                    if (r_work[r_probe] == 4'd0) begin
                        r_work[r_probe] <= (r_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
                        if (r_spawn2) begin
                            r_spawn2 <= 1'b0;
                            r_probe  <= r_lfsr[3:0];
                        end else begin
                            r_fsm <= S_CHECK;
                        end
                    end else begin
                        r_probe <= r_probe + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (w_won)                  r_result <= 2'd1;
                    else if (!w_empty && !w_pair) r_result <= 2'd2;
                    else                        r_result <= 2'd0;
                    r_fsm <= S_WAIT_VB;
                end
                S_WAIT_VB: begin
                    if (vc >= 10'd480) begin
                        for (int i = 0; i < 16; i++) grid[i] <= r_work[i];
                        state   <= r_result;
                        r_ready <= 1'b1;
                        r_fsm   <= S_IDLE;
                    end
                end
                default: r_fsm <= S_INIT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
// Module : tb_game_ctrl
// Brief  : Directed, table-driven bench for game_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl;

    logic       vgaclk = 1'b0;
    logic       rst    = 1'b0;
    logic [9:0] vc     = 10'd480;
    logic [3:0] grid [0:15];
    logic [1:0] state;

    game_ctrl_if bus ();

    game_ctrl #(
        .WIN_VALUE (11),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .vgaclk (vgaclk),
        .rst    (rst),
        .vc     (vc),
        .bus    (bus),
        .grid   (grid),
        .state  (state)
    );

    always #20 vgaclk = ~vgaclk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] load;
        logic [1:0]  dir;
        logic [63:0] exp;      // cells that must hold these values; zero cells free for spawn
        logic        changed;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs [0:8];

    task automatic tick();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] grid_flat();
        logic [63:0] g;
        for (int i = 0; i < 16; i++) g[4*i +: 4] = grid[i];
        return g;
    endfunction

    function automatic int count_tiles();
        int n = 0;
        for (int i = 0; i < 16; i++) if (grid[i] != 4'd0) n++;
        return n;
    endfunction

    function automatic int count_big();
        int n = 0;
        for (int i = 0; i < 16; i++) if (grid[i] > 4'd2) n++;
        return n;
    endfunction

    task automatic wait_ready(input string nm, input int budget);
        int n = 0;
        while (!bus.move_ready && n < budget) begin
            tick();
            n++;
        end
        if (!bus.move_ready) begin
            checks++;
            failures++;
            $display("FAIL %s timeout move_ready=0 required=1", nm);
        end
    endtask

    task automatic do_load(input logic [63:0] d);
        wait_ready("load_ready", 200);
        bus.load_en   = 1'b1;
        bus.load_data = d;
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] dir);
        wait_ready("move_ready", 200);
        bus.move_valid = 1'b1;
        bus.move_dir   = dir;
        tick();
        bus.move_valid = 1'b0;
    endtask

    task automatic check_vec(input int k, input vec_t v);
        logic [63:0] g, det;
        int spawned, badval;
        g = grid_flat();
        det = 64'd0;
        spawned = 0;
        badval = 0;
        for (int i = 0; i < 16; i++) begin
            if (v.exp[4*i +: 4] != 4'd0) det[4*i +: 4] = g[4*i +: 4];
            else if (g[4*i +: 4] != 4'd0) begin
                spawned++;
                if (g[4*i +: 4] > 4'd2) badval++;
            end
        end
        chk($sformatf("vec%0d_cells", k), det, v.exp);
        chk($sformatf("vec%0d_spawn_count", k), 64'(spawned), 64'(v.changed));
        chk($sformatf("vec%0d_spawn_value", k), 64'(badval), 64'd0);
        chk($sformatf("vec%0d_state", k), 64'(state), 64'(v.st));
    endtask

    initial begin
        logic [63:0] snap;
        int n;
        logic hold_ok;

        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        bus.new_game   = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_data  = 64'd0;

        //            load                    dir   expected                changed state
        vecs[0] = '{64'h0000_0000_0000_2211, 2'd0, 64'h0000_0000_0000_0032, 1'b1, 2'd0};
        vecs[1] = '{64'h0000_0000_0000_1111, 2'd0, 64'h0000_0000_0000_0022, 1'b1, 2'd0};
        vecs[2] = '{64'h0000_0000_0000_2002, 2'd1, 64'h0000_0000_0000_3000, 1'b1, 2'd0};
        vecs[3] = '{64'h0000_0001_0000_0001, 2'd3, 64'h0002_0000_0000_0000, 1'b1, 2'd0};
        vecs[4] = '{64'h0010_0000_0010_0000, 2'd2, 64'h0000_0000_0000_0020, 1'b1, 2'd0};
        vecs[5] = '{64'h0000_0000_00FF_0000, 2'd1, 64'h0000_0000_FF00_0000, 1'b1, 2'd1};
        vecs[6] = '{64'h0000_0333_0000_0000, 2'd1, 64'h0000_4300_0000_0000, 1'b1, 2'd0};
        vecs[7] = '{64'h0765_3434_1212_2121, 2'd1, 64'h7650_3434_1212_2121, 1'b1, 2'd2};
        vecs[8] = '{64'h0000_0000_0000_00AA, 2'd0, 64'h0000_0000_0000_000B, 1'b1, 2'd1};

        // Reset state, then the power-up INIT commit.
        repeat (3) tick();
        chk("reset_grid", grid_flat(), 64'd0);
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_ready", 64'(bus.move_ready), 64'd0);
        rst = 1'b1;
        wait_ready("init_commit", 200);
        chk("init_tiles", 64'(count_tiles()), 64'd2);
        chk("init_values", 64'(count_big()), 64'd0);
        chk("init_state", 64'(state), 64'd0);

        for (int k = 0; k < 9; k++) begin
            do_load(vecs[k].load);
            do_move(vecs[k].dir);
            wait_ready($sformatf("vec%0d_commit", k), 100);
            check_vec(k, vecs[k]);
        end

        // Game is WON: moves are swallowed, then new_game restarts.
        snap = grid_flat();
        do_move(2'd1);
        repeat (20) tick();
        chk("won_move_ignored", grid_flat(), snap);
        chk("won_state_kept", 64'(state), 64'd1);
        chk("won_ready", 64'(bus.move_ready), 64'd1);
        wait_ready("newgame_ready", 50);
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        wait_ready("newgame_commit", 200);
        chk("newgame_tiles", 64'(count_tiles()), 64'd2);
        chk("newgame_values", 64'(count_big()), 64'd0);
        chk("newgame_state", 64'(state), 64'd0);

        // Move that changes nothing: fast return, no spawn.
        do_load(64'h0000_0000_0000_0021);
        do_move(2'd0);
        n = 0;
        while (!bus.move_ready && n < 20) begin
            tick();
            n++;
        end
        chk("nomove_latency_ok", 64'(n <= 6), 64'd1);
        chk("nomove_grid", grid_flat(), 64'h0000_0000_0000_0021);

        // Commit is held off until vblank.
        vc = 10'd100;
        do_load(64'h0000_0000_0000_0011);
        do_move(2'd0);
        hold_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (grid_flat() !== 64'h0000_0000_0000_0011 || state !== 2'd0 || bus.move_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        chk("vblank_hold", 64'(hold_ok), 64'd1);
        vc = 10'd480;
        tick();
        chk("vblank_commit_cell0", 64'(grid[0]), 64'd2);
        chk("vblank_commit_tiles", 64'(count_tiles()), 64'd2);
        chk("vblank_commit_ready", 64'(bus.move_ready), 64'd1);

        // Asynchronous reset in the middle of a slide.
        vc = 10'd100;
        do_load(64'h0000_0000_0000_0011);
        do_move(2'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("midreset_grid", grid_flat(), 64'd0);
        chk("midreset_ready", 64'(bus.move_ready), 64'd0);
        chk("midreset_state", 64'(state), 64'd0);
        tick();
        rst = 1'b1;
        repeat (50) tick();
        chk("midreset_no_commit", grid_flat(), 64'd0);
        vc = 10'd480;
        wait_ready("midreset_commit", 50);
        chk("midreset_init_tiles", 64'(count_tiles()), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
